// File: rtl/mem_exc_checker_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_exc_checker_pkg
//  Purpose  : Shared exception codes, DM access modes and region flag layout
//  Revision : 1.0 - initial release
// ============================================================================
package mem_exc_checker_pkg;

    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;

    localparam logic [1:0] DM_MODE_WORD = 2'd0;
    localparam logic [1:0] DM_MODE_HALF = 2'd1;
    localparam logic [1:0] DM_MODE_BYTE = 2'd2;
    localparam logic [1:0] DM_MODE_ILL  = 2'd3;

    // Region flag word layout: {word_only, writable, enable}
    localparam int FLAG_EN = 0;
    localparam int FLAG_WR = 1;
    localparam int FLAG_WO = 2;
    localparam int FLAGS_W = 3;

endpackage : mem_exc_checker_pkg
`default_nettype wire

// File: rtl/mem_region_match.sv
`default_nettype none
// ============================================================================
//  Module   : mem_region_match
//  Purpose  : Combinational lookup of an address in the region table;
//             lowest matching enabled entry wins
//  Revision : 1.0 - initial release
// ============================================================================
module mem_region_match
    import mem_exc_checker_pkg::*;
#(
    parameter int NUM_REGIONS = 4,
    parameter int ADDR_W      = 32
) (
    input  logic [NUM_REGIONS*ADDR_W-1:0]  i_bases,
    input  logic [NUM_REGIONS*ADDR_W-1:0]  i_limits,
    input  logic [NUM_REGIONS*FLAGS_W-1:0] i_flags,
    input  logic [ADDR_W-1:0]              i_addr,
    output logic                           o_hit,
    output logic [2:0]                     o_idx,
    output logic [FLAGS_W-1:0]             o_flags
);

    logic [NUM_REGIONS-1:0] w_match;

    generate
        for (genvar gi = 0; gi < NUM_REGIONS; gi++) begin : g_entry
            assign w_match[gi] = i_flags[gi*FLAGS_W + FLAG_EN]
                              && (i_addr >= i_bases[gi*ADDR_W +: ADDR_W])
                              && (i_addr <= i_limits[gi*ADDR_W +: ADDR_W]);
        end
    endgenerate

    // Scan from the top down so the lowest matching index is the last writer
    always_comb begin
        o_hit   = 1'b0;
        o_idx   = 3'd0;
        o_flags = '0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if (w_match[i]) begin
                o_hit   = 1'b1;
                o_idx   = 3'(i);
                o_flags = i_flags[i*FLAGS_W +: FLAGS_W];
            end
        end
    end

endmodule : mem_region_match
`default_nettype wire

// File: rtl/mem_exc_checker.sv
`default_nettype none
// ============================================================================
//  Module   : mem_exc_checker
//  Purpose  : M-stage data-memory exception classifier with programmable
//             region table, one-cycle result and sticky fault capture
//  Revision : 1.0 - initial release
// ============================================================================
module mem_exc_checker
    import mem_exc_checker_pkg::*;
#(
    parameter int NUM_REGIONS = 4,
    parameter int ADDR_W      = 32,
    parameter logic [NUM_REGIONS*ADDR_W-1:0]  BASE_INIT  = {32'h7F10, 32'h7F00, 32'h3000, 32'h0000},
    parameter logic [NUM_REGIONS*ADDR_W-1:0]  LIMIT_INIT = {32'h7F1B, 32'h7F0B, 32'h3FFF, 32'h2FFF},
    parameter logic [NUM_REGIONS*FLAGS_W-1:0] FLAGS_INIT = {3'b111, 3'b111, 3'b001, 3'b011}
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                MEC_i_Valid,
    input  logic [4:0]          MEC_i_UpExcCode,
    input  logic                MEC_i_WEnable,
    input  logic                MEC_i_REnable,
    input  logic [ADDR_W-1:0]   MEC_i_Addr,
    input  logic [1:0]          MEC_i_Mode,
    input  logic                MEC_i_CfgWe,
    input  logic [2:0]          MEC_i_CfgIdx,
    input  logic [ADDR_W-1:0]   MEC_i_CfgBase,
    input  logic [ADDR_W-1:0]   MEC_i_CfgLimit,
    input  logic [FLAGS_W-1:0]  MEC_i_CfgFlags,
    input  logic                MEC_i_FaultClr,
    output logic                MEC_o_Valid,
    output logic [4:0]          MEC_o_ExcCode,
    output logic                MEC_o_FaultPending,
    output logic [4:0]          MEC_o_FaultCode,
    output logic [ADDR_W-1:0]   MEC_o_FaultAddr,
    output logic [7:0]          MEC_o_FaultCnt
);

    logic [ADDR_W-1:0]  r_base  [NUM_REGIONS];
    logic [ADDR_W-1:0]  r_limit [NUM_REGIONS];
    logic [FLAGS_W-1:0] r_flags [NUM_REGIONS];

    logic [NUM_REGIONS*ADDR_W-1:0]  w_bases_flat;
    logic [NUM_REGIONS*ADDR_W-1:0]  w_limits_flat;
    logic [NUM_REGIONS*FLAGS_W-1:0] w_flags_flat;

    logic               w_hit;
    logic [2:0]         w_hit_idx;
    logic [FLAGS_W-1:0] w_hit_flags;
    logic               w_unused_idx;

    logic               w_store;
    logic               w_is_word;
    logic               w_misalign;
    logic [4:0]         w_addr_exc;
    logic [4:0]         w_code;
    logic               w_fault_now;

    logic               r_valid;
    logic [4:0]         r_code;
    logic [ADDR_W-1:0]  r_addr;
    logic               r_pending;
    logic [4:0]         r_fault_code;
    logic [ADDR_W-1:0]  r_fault_addr;
    logic [7:0]         r_fault_cnt;

    // Table writes land at the edge, so an access sampled on that same edge
    // still sees the old entry through the combinational lookup.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REGIONS; i++) begin
            if (reset) begin
                r_base[i]  <= BASE_INIT[i*ADDR_W +: ADDR_W];
                r_limit[i] <= LIMIT_INIT[i*ADDR_W +: ADDR_W];
                r_flags[i] <= FLAGS_INIT[i*FLAGS_W +: FLAGS_W];
            end else if (MEC_i_CfgWe && (MEC_i_CfgIdx == 3'(i))) begin
                r_base[i]  <= MEC_i_CfgBase;
                r_limit[i] <= MEC_i_CfgLimit;
                r_flags[i] <= MEC_i_CfgFlags;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_REGIONS; gi++) begin : g_flatten
            assign w_bases_flat[gi*ADDR_W +: ADDR_W]    = r_base[gi];
            assign w_limits_flat[gi*ADDR_W +: ADDR_W]   = r_limit[gi];
            assign w_flags_flat[gi*FLAGS_W +: FLAGS_W]  = r_flags[gi];
        end
    endgenerate

    mem_region_match #(
        .NUM_REGIONS (NUM_REGIONS),
        .ADDR_W      (ADDR_W)
    ) u_region_match (
        .i_bases  (w_bases_flat),
        .i_limits (w_limits_flat),
        .i_flags  (w_flags_flat),
        .i_addr   (MEC_i_Addr),
        .o_hit    (w_hit),
        .o_idx    (w_hit_idx),
        .o_flags  (w_hit_flags)
    );

    assign w_unused_idx = &{1'b0, w_hit_idx};

    // A load+store collision classifies as a store; mode 3 behaves as word
    assign w_store    = MEC_i_WEnable;
    assign w_is_word  = (MEC_i_Mode == DM_MODE_WORD) || (MEC_i_Mode == DM_MODE_ILL);
    assign w_addr_exc = w_store ? EXC_ADES : EXC_ADEL;

    always_comb begin
        w_misalign = 1'b0;
        case (MEC_i_Mode)
            DM_MODE_HALF: w_misalign = MEC_i_Addr[0];
            DM_MODE_BYTE: w_misalign = 1'b0;
            default:      w_misalign = |MEC_i_Addr[1:0];
        endcase
    end

    always_comb begin
        w_code = EXC_NONE;
        if (MEC_i_UpExcCode != EXC_NONE)
            w_code = MEC_i_UpExcCode;
        else if (!MEC_i_WEnable && !MEC_i_REnable)
            w_code = EXC_NONE;
        else if (w_misalign)
            w_code = w_addr_exc;
        else if (!w_hit)
            w_code = w_addr_exc;
        else if (w_hit_flags[FLAG_WO] && !w_is_word)
            w_code = w_addr_exc;
        else if (w_store && !w_hit_flags[FLAG_WR])
            w_code = EXC_ADES;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_code  <= EXC_NONE;
            r_addr  <= '0;
        end else begin
            r_valid <= MEC_i_Valid;
            r_code  <= MEC_i_Valid ? w_code : EXC_NONE;
            r_addr  <= MEC_i_Addr;
        end
    end

    assign w_fault_now = r_valid && (r_code != EXC_NONE);

    // A fault on the outputs beats a simultaneous acknowledge
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending    <= 1'b0;
            r_fault_code <= EXC_NONE;
            r_fault_addr <= '0;
        end else if (w_fault_now && (!r_pending || MEC_i_FaultClr)) begin
            r_pending    <= 1'b1;
            r_fault_code <= r_code;
            r_fault_addr <= r_addr;
        end else if (MEC_i_FaultClr) begin
            r_pending    <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_fault_cnt <= 8'd0;
        else if (w_fault_now && (r_fault_cnt != 8'hFF))
            r_fault_cnt <= r_fault_cnt + 8'd1;
    end

    assign MEC_o_Valid        = r_valid;
    assign MEC_o_ExcCode      = r_code;
    assign MEC_o_FaultPending = r_pending;
    assign MEC_o_FaultCode    = r_fault_code;
    assign MEC_o_FaultAddr    = r_fault_addr;
    assign MEC_o_FaultCnt     = r_fault_cnt;

endmodule : mem_exc_checker
`default_nettype wire

// File: tb/tb_mem_exc_checker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_exc_checker
//  Purpose  : Directed scoreboard bench for mem_exc_checker
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_exc_checker;

    typedef struct {
        logic [4:0]  code;
        logic [31:0] addr;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        r_valid_in;
    logic [4:0]  r_up;
    logic        r_we;
    logic        r_re;
    logic [31:0] r_addr;
    logic [1:0]  r_mode;
    logic        r_cfg_we;
    logic [2:0]  r_cfg_idx;
    logic [31:0] r_cfg_base;
    logic [31:0] r_cfg_limit;
    logic [2:0]  r_cfg_flags;
    logic        r_clr;

    logic        w_valid;
    logic [4:0]  w_exc;
    logic        w_pending;
    logic [4:0]  w_fcode;
    logic [31:0] w_faddr;
    logic [7:0]  w_fcnt;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    mem_exc_checker u_dut (
        .clk                (clk),
        .reset              (reset),
        .MEC_i_Valid        (r_valid_in),
        .MEC_i_UpExcCode    (r_up),
        .MEC_i_WEnable      (r_we),
        .MEC_i_REnable      (r_re),
        .MEC_i_Addr         (r_addr),
        .MEC_i_Mode         (r_mode),
        .MEC_i_CfgWe        (r_cfg_we),
        .MEC_i_CfgIdx       (r_cfg_idx),
        .MEC_i_CfgBase      (r_cfg_base),
        .MEC_i_CfgLimit     (r_cfg_limit),
        .MEC_i_CfgFlags     (r_cfg_flags),
        .MEC_i_FaultClr     (r_clr),
        .MEC_o_Valid        (w_valid),
        .MEC_o_ExcCode      (w_exc),
        .MEC_o_FaultPending (w_pending),
        .MEC_o_FaultCode    (w_fcode),
        .MEC_o_FaultAddr    (w_faddr),
        .MEC_o_FaultCnt     (w_fcnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one access for one edge and queue its expected exception code
    task automatic acc(input logic [4:0] up, input logic we, input logic re,
                       input logic [31:0] addr, input logic [1:0] mode,
                       input logic [4:0] exp_code);
        exp_t e;
        r_valid_in = 1'b1;
        r_up       = up;
        r_we       = we;
        r_re       = re;
        r_addr     = addr;
        r_mode     = mode;
        e.code     = exp_code;
        e.addr     = addr;
        exp_q.push_back(e);
        tick();
        r_valid_in = 1'b0;
        r_up       = 5'd0;
        r_we       = 1'b0;
        r_re       = 1'b0;
        r_cfg_we   = 1'b0;
    endtask

    task automatic set_cfg(input logic [2:0] idx, input logic [31:0] base,
                           input logic [31:0] limit, input logic [2:0] flags);
        r_cfg_we    = 1'b1;
        r_cfg_idx   = idx;
        r_cfg_base  = base;
        r_cfg_limit = limit;
        r_cfg_flags = flags;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_valid"},   32'(w_valid),   32'd0);
        check({tag, "_exc"},     32'(w_exc),     32'd0);
        check({tag, "_pending"}, 32'(w_pending), 32'd0);
        check({tag, "_fcode"},   32'(w_fcode),   32'd0);
        check({tag, "_faddr"},   w_faddr,        32'd0);
        check({tag, "_fcnt"},    32'(w_fcnt),    32'd0);
    endtask

    // Scoreboard monitor: every valid result pops one expectation
    always @(negedge clk) begin
        if (!reset) begin
            if (w_valid) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_result: got code %0d, expected no result", w_exc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (w_exc !== e.code) begin
                        n_fail++;
                        $display("FAIL exc_code@0x%0h: got %0d, expected %0d", e.addr, w_exc, e.code);
                    end
                end
            end else if (w_exc !== 5'd0) begin
                n_checks++;
                n_fail++;
                $display("FAIL idle_exc: got %0d, expected 0", w_exc);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; r_valid_in = 1'b0; r_up = 5'd0; r_we = 1'b0; r_re = 1'b0;
        r_addr = 32'd0; r_mode = 2'd0; r_cfg_we = 1'b0; r_cfg_idx = 3'd0;
        r_cfg_base = 32'd0; r_cfg_limit = 32'd0; r_cfg_flags = 3'd0; r_clr = 1'b0;
        repeat (3) tick();
        check_outputs_zero("reset");
        reset = 1'b0;
        tick();

        // Default table, alignment and width rules
        acc(5'd0, 1'b0, 1'b1, 32'h1000,  2'd0, 5'd0);
        acc(5'd0, 1'b1, 1'b0, 32'h7F04,  2'd0, 5'd0);
        acc(5'd0, 1'b1, 1'b0, 32'h3004,  2'd0, 5'd5);
        acc(5'd0, 1'b0, 1'b1, 32'h7F03,  2'd1, 5'd4);
        acc(5'd0, 1'b1, 1'b0, 32'h7F04,  2'd2, 5'd5);
        acc(5'd0, 1'b0, 1'b1, 32'h15152, 2'd0, 5'd4);
        acc(5'd0, 1'b0, 1'b1, 32'h1002,  2'd3, 5'd4);
        acc(5'd0, 1'b1, 1'b1, 32'h3000,  2'd0, 5'd5);
        acc(5'd0, 1'b0, 1'b1, 32'h1001,  2'd2, 5'd0);
        tick();
        check("g1_pending", 32'(w_pending), 32'd1);
        check("g1_fcode",   32'(w_fcode),   32'd5);
        check("g1_faddr",   w_faddr,        32'h3004);
        check("g1_fcnt",    32'(w_fcnt),    32'd6);

        // Upstream code wins over everything
        do_reset();
        acc(5'd12, 1'b0, 1'b1, 32'h3204, 2'd0, 5'd12);
        acc(5'd0,  1'b0, 1'b0, 32'h9999, 2'd0, 5'd0);
        tick();
        check("up_fcode", 32'(w_fcode), 32'd12);
        check("up_faddr", w_faddr,      32'h3204);
        check("up_fcnt",  32'(w_fcnt),  32'd1);

        // Sticky capture, then acknowledge colliding with a new fault
        do_reset();
        acc(5'd0, 1'b0, 1'b1, 32'h5000, 2'd0, 5'd4);
        acc(5'd0, 1'b0, 1'b1, 32'h6000, 2'd0, 5'd4);
        tick();
        check("sticky_faddr", w_faddr,       32'h5000);
        check("sticky_fcnt",  32'(w_fcnt),   32'd2);
        acc(5'd0, 1'b0, 1'b1, 32'h6004, 2'd0, 5'd4);
        r_clr = 1'b1;
        tick();
        r_clr = 1'b0;
        check("clrwin_faddr",   w_faddr,         32'h6004);
        check("clrwin_pending", 32'(w_pending),  32'd1);
        check("clrwin_fcnt",    32'(w_fcnt),     32'd3);
        r_clr = 1'b1;
        tick();
        r_clr = 1'b0;
        check("clr_pending", 32'(w_pending), 32'd0);
        check("clr_fcnt",    32'(w_fcnt),    32'd3);

        // Config hazard, out-of-range index, overlap priority, inclusive limit
        do_reset();
        set_cfg(3'd3, 32'h5000, 32'h5FFF, 3'b011);
        acc(5'd0, 1'b1, 1'b0, 32'h5000, 2'd0, 5'd5);
        acc(5'd0, 1'b1, 1'b0, 32'h5000, 2'd0, 5'd0);
        set_cfg(3'd5, 32'h6000, 32'h6FFF, 3'b011);
        acc(5'd0, 1'b1, 1'b0, 32'h6000, 2'd0, 5'd5);
        acc(5'd0, 1'b1, 1'b0, 32'h6000, 2'd0, 5'd5);
        set_cfg(3'd1, 32'h5000, 32'h5FFF, 3'b001);
        acc(5'd0, 1'b1, 1'b0, 32'h5000, 2'd0, 5'd0);
        acc(5'd0, 1'b1, 1'b0, 32'h5000, 2'd0, 5'd5);
        acc(5'd0, 1'b0, 1'b1, 32'h5FFC, 2'd0, 5'd0);
        acc(5'd0, 1'b0, 1'b1, 32'h5FFF, 2'd2, 5'd0);
        acc(5'd0, 1'b0, 1'b1, 32'h6000, 2'd0, 5'd4);
        acc(5'd0, 1'b0, 1'b1, 32'h3000, 2'd0, 5'd4);

        // Counter saturation
        for (int i = 0; i < 300; i++)
            acc(5'd0, 1'b0, 1'b1, 32'h8000, 2'd0, 5'd4);
        tick();
        check("sat_fcnt",    32'(w_fcnt),    32'd255);
        check("sat_pending", 32'(w_pending), 32'd1);

        // Reset with a fault pending and an access in flight
        r_valid_in = 1'b1; r_re = 1'b1; r_addr = 32'h8000; r_mode = 2'd0;
        reset = 1'b1;
        tick();
        r_valid_in = 1'b0; r_re = 1'b0;
        tick();
        check_outputs_zero("midrst");
        reset = 1'b0;
        acc(5'd0, 1'b1, 1'b0, 32'h5000, 2'd0, 5'd5);
        acc(5'd0, 1'b1, 1'b0, 32'h7F04, 2'd0, 5'd0);
        acc(5'd0, 1'b0, 1'b1, 32'h3000, 2'd0, 5'd0);
        acc(5'd0, 1'b0, 1'b1, 32'h7F18, 2'd0, 5'd0);
        acc(5'd0, 1'b0, 1'b1, 32'h7F1C, 2'd0, 5'd4);
        tick();
        check("post_faddr", w_faddr,      32'h5000);
        check("post_fcnt",  32'(w_fcnt),  32'd2);
        @(negedge clk);
        #1;
        check("scoreboard_drain", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_mem_exc_checker
`default_nettype wire
